mux_scan_seq: RTL and testbench

Sequencer that serializes a captured 32-bit word through an external 32:1 bit-select mux. It owns the mux's data and select inputs, steps the select LSB-first or MSB-first over a programmable bit count, and presents each selected bit on a valid/ready stream. It sits between a parallel register source and any bit-serial consumer (serial link, debug shifter, bit-test logic). The mux itself stays outside the block.

---
 rtl/mux_scan_seq.sv | 106 ++++++++++
 tb/tb_mux_scan_seq.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/mux_scan_seq.sv
// Bit-serial scan sequencer. Captures a word, steps an external 32:1 mux
// select LSB- or MSB-first over len+1 bits, and offers each bit on a valid/ready stream.
module mux_scan_seq #(
   parameter int WIDTH = 32,
   parameter int SEL_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] word,
   input  logic [SEL_W-1:0] len,
   input  logic             msb_first,
   input  logic             abort,
   output logic [WIDTH-1:0] mux_w,
   output logic [SEL_W-1:0] sel,
   input  logic             mux_out,
   output logic             bit_out,
   output logic             bit_valid,
   input  logic             bit_ready,
   output logic             last,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] mux_w_q, mux_w_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [SEL_W-1:0] count_q, count_d;
   logic [SEL_W-1:0] len_q, len_d;
   logic             msb_q, msb_d;

   logic accept;
   logic xfer;
   logic at_end;

   assign accept = (state_q == IDLE) && start && !abort;
   assign xfer   = (state_q == SHIFT) && bit_ready && !abort;
   assign at_end = (count_q == len_q);

   // NOTE: every register, including the captured word, is cleared by reset so
   // the mux inputs and all outputs are defined immediately on assertion.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         mux_w_q <= '0;
         sel_q   <= '0;
         count_q <= '0;
         len_q   <= '0;
         msb_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so all flops sample the same pre-edge values.
         state_q <= state_d;
         mux_w_q <= mux_w_d;
         sel_q   <= sel_d;
         count_q <= count_d;
         len_q   <= len_d;
         msb_q   <= msb_d;
      end
   end

   always_comb begin
      // NOTE: default-first assignment keeps this block free of inferred latches.
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = SHIFT;
         SHIFT: begin
            if (abort)               state_d = IDLE;
            else if (xfer && at_end) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath changes only on an accepted start or a non-final transfer.
   always_comb begin
      mux_w_d = mux_w_q;
      sel_d   = sel_q;
      count_d = count_q;
      len_d   = len_q;
      msb_d   = msb_q;
      if (accept) begin
         mux_w_d = word;
         len_d   = len;
         msb_d   = msb_first;
         count_d = '0;
         sel_d   = msb_first ? len : '0;
      end else if (xfer && !at_end) begin
         count_d = count_q + SEL_W'(1);
         sel_d   = msb_q ? (sel_q - SEL_W'(1)) : (sel_q + SEL_W'(1));
      end
   end

   always_comb begin
      bit_valid = (state_q == SHIFT);
      busy      = (state_q == SHIFT) || (state_q == DONE);
      done      = (state_q == DONE);
      last      = bit_valid && at_end;
      bit_out   = mux_out && bit_valid;
      mux_w     = mux_w_q;
      sel       = sel_q;
   end

endmodule

// File: tb/tb_mux_scan_seq.sv
// Randomized bench for mux_scan_seq: an external mux model plus a per-scan
// expected bit list derived from the word, length and order.
module tb_mux_scan_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        start, msb_first, abort, bit_ready;
   logic [31:0] word;
   logic [4:0]  len;
   logic [31:0] mux_w;
   logic [4:0]  sel;
   logic        mux_out, bit_out, bit_valid, last, busy, done;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign mux_out = mux_w[sel];

   mux_scan_seq dut (
      .clk(clk), .reset(reset), .start(start), .word(word), .len(len),
      .msb_first(msb_first), .abort(abort), .mux_w(mux_w), .sel(sel),
      .mux_out(mux_out), .bit_out(bit_out), .bit_valid(bit_valid),
      .bit_ready(bit_ready), .last(last), .busy(busy), .done(done)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_valid"}, bit_valid, 0);
      check({tag, "_busy"},  busy, 0);
      check({tag, "_done"},  done, 0);
      check({tag, "_last"},  last, 0);
      check({tag, "_bit"},   bit_out, 0);
   endtask

   // Runs one scan, entered and left at a negedge.
   // cut_kind: 0 none, 1 abort at bit cut_at, 2 async reset at bit cut_at.
   task automatic scan(input logic [31:0] w, input int l, input logic m,
                       input int stall_pct, input int stall_k, input bit spam,
                       input int cut_at, input int cut_kind);
      int k = 0, cyc = 1, stalls = 0, held = 0, idx;
      bit rdy;
      start = 1'b1; word = w; len = 5'(l); msb_first = m; bit_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      word = $urandom; len = 5'($urandom); msb_first = 1'($urandom);
      check("mux_w", mux_w, w);
      while (k <= l) begin
         idx = m ? (l - k) : k;
         check("valid", bit_valid, 1);
         check("busy",  busy, 1);
         check("done",  done, 0);
         check("sel",   sel, 32'(idx));
         check("bit",   bit_out, w[idx]);
         check("last",  last, (k == l));
         if (cut_kind == 1 && k == cut_at) begin
            abort = 1'b1; bit_ready = 1'b1;
            @(negedge clk);
            abort = 1'b0; bit_ready = 1'b0;
            check_quiet("abort");
            check("abort_sel_hold", sel, 32'(idx));
            return;
         end
         if (cut_kind == 2 && k == cut_at) begin
            #2 reset = 1'b1;
            #1;
            check_quiet("rst");
            check("rst_sel", sel, 0);
            check("rst_mux_w", mux_w, 0);
            @(negedge clk);
            reset = 1'b0;
            return;
         end
         if (k == stall_k && held < 3) begin
            rdy = 1'b0; held++;
         end else begin
            rdy = ($urandom_range(99) >= stall_pct);
         end
         bit_ready = rdy;
         start = spam ? 1'($urandom) : 1'b0;
         if (rdy) k++;
         else stalls++;
         @(negedge clk);
         cyc++;
         if (cyc > 200) begin
            check("timeout", 0, 1);
            return;
         end
      end
      start = 1'b0; bit_ready = 1'($urandom);
      check("done_pulse", done, 1);
      check("done_busy",  busy, 1);
      check("done_valid", bit_valid, 0);
      check("done_cycle", cyc, l + 2 + stalls);
      @(negedge clk);
      check_quiet("idle");
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; abort = 1'b0; bit_ready = 1'b0;
      word = '0; len = '0; msb_first = 1'b0;
      #1;
      check_quiet("por");
      check("por_sel", sel, 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Async reset at bit 10, then a single-bit scan right after release.
      scan(32'hDEAD_BEEF, 31, 1'b0, 0, -1, 1'b0, 10, 2);
      scan(32'h0000_0001, 0, 1'b0, 0, -1, 1'b0, -1, 0);

      // Directed cases.
      scan(32'h5555_5555, 31, 1'b0, 0, -1, 1'b0, -1, 0);
      scan(32'h8000_0081, 7, 1'b1, 0, -1, 1'b0, -1, 0);
      scan(32'h5555_5555, 31, 1'b0, 0, 4, 1'b0, -1, 0);
      scan(32'hA5A5_0F0F, 31, 1'b0, 0, -1, 1'b0, 5, 1);
      @(negedge clk);
      scan(32'h1234_5678, 15, 1'b0, 0, -1, 1'b0, -1, 0);
      scan(32'h0000_00C3, 7, 1'b0, 0, -1, 1'b1, -1, 0);
      scan(32'h0000_0000, 0, 1'b0, 0, -1, 1'b0, -1, 0);

      // abort in IDLE blocks a coincident start.
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      check_quiet("idle_abort");

      // Randomized scans with backpressure, start spam and occasional aborts.
      for (int i = 0; i < 30; i++) begin
         int l;
         l = $urandom_range(31);
         scan($urandom, l, 1'($urandom), 30, -1, 1'($urandom),
              $urandom_range(l), ($urandom_range(3) == 0) ? 1 : 0);
         if ($urandom_range(1) == 1) @(negedge clk);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
